// File: rtl/fpga_btn_conditioner.sv
// Button conditioner: 2FF sync, per-channel debounce, press pulses, stretched reset (FPGA_BTN_AUTOREPEAT_EN adds auto-repeat).
// Latency: raw edge to btn_level/btn_press is 2 + DEBOUNCE_CYCLES cycles; reset release to rst_out_n high is RST_HOLD_CYCLES.
// Backpressure: none, outputs are free-running levels and single-cycle pulses.
module fpga_btn_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               btn_rst,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               rst_out_n
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

    if (NUM_BTN < 1 || NUM_BTN > 16 || DEBOUNCE_CYCLES < 2 || RST_HOLD_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("fpga_btn_conditioner: parameter out of range");
    end

    logic [NUM_BTN-1:0] btn_s1_q, btn_s2_q;
    logic               rst_s1_q, rst_s2_q;
    logic [CW-1:0]      deb_cnt_q [NUM_BTN];
    logic [CW-1:0]      deb_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] toggle, rise;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic               rst_n_q, rst_n_d;

    always_comb begin
        toggle = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            deb_cnt_d[i] = '0;
            if (btn_s2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    toggle[i] = 1'b1;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
        level_d = level_q ^ toggle;
        rise    = toggle & ~level_q;
    end

`ifdef FPGA_BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]      rep_cnt_q [NUM_BTN];
    logic [RW-1:0]      rep_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] rep_arm_q, rep_arm_d, rep_fire;

    // rep_arm_q selects the period phase once the initial delay has elapsed.
    always_comb begin
        rep_fire  = '0;
        rep_arm_d = rep_arm_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            rep_cnt_d[i] = rep_cnt_q[i];
            if (!level_q[i] || toggle[i]) begin
                rep_cnt_d[i] = '0;
                rep_arm_d[i] = 1'b0;
            end else if ((!rep_arm_q[i] && rep_cnt_q[i] == DLY_LAST) ||
                         ( rep_arm_q[i] && rep_cnt_q[i] == PER_LAST)) begin
                rep_fire[i]  = 1'b1;
                rep_cnt_d[i] = '0;
                rep_arm_d[i] = 1'b1;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_arm_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) rep_cnt_q[i] <= '0;
        end else begin
            rep_arm_q <= rep_arm_d;
            for (int i = 0; i < NUM_BTN; i++) rep_cnt_q[i] <= rep_cnt_d[i];
        end
    end

    assign press_d = rise | rep_fire;
`else
    assign press_d = rise;
`endif

    // btn_rst is deliberately not debounced: any synced high cycle restarts the hold.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        rst_n_d    = rst_n_q;
        if (rst_s2_q) begin
            hold_cnt_d = '0;
            rst_n_d    = 1'b0;
        end else if (!rst_n_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
                hold_cnt_d = '0;
                rst_n_d    = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            rst_s1_q   <= 1'b0;
            rst_s2_q   <= 1'b0;
            level_q    <= '0;
            press_q    <= '0;
            hold_cnt_q <= '0;
            rst_n_q    <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) deb_cnt_q[i] <= '0;
        end else begin
            btn_s1_q   <= btn_raw;
            btn_s2_q   <= btn_s1_q;
            rst_s1_q   <= btn_rst;
            rst_s2_q   <= rst_s1_q;
            level_q    <= level_d;
            press_q    <= press_d;
            hold_cnt_q <= hold_cnt_d;
            rst_n_q    <= rst_n_d;
            for (int i = 0; i < NUM_BTN; i++) deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;
    assign rst_out_n = rst_n_q;

endmodule

// File: doc/fpga_btn_conditioner.md
FPGA_BTN_CONDITIONER -- requirements
Module: fpga_btn_conditioner

Interface
REQ-001 SHALL have parameter NUM_BTN, default 5, number of button channels (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles required to accept a level change (>=2).
REQ-003 SHALL have parameter RST_HOLD_CYCLES, default 16, cycles rst_out_n is held low after the reset sources release (>=1).
REQ-004 SHALL have parameter REPEAT_DELAY, default 50000000, cycles from accepted press to first auto-repeat pulse.
REQ-005 SHALL have parameter REPEAT_PERIOD, default 10000000, cycles between subsequent auto-repeat pulses.
REQ-006 clk  input  1  single system clock; all state on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 btn_raw  input  NUM_BTN  asynchronous raw button levels, 1 = pressed.
REQ-009 btn_rst  input  1  asynchronous raw reset button, 1 = pressed.
REQ-010 btn_level  output  NUM_BTN  debounced button levels.
REQ-011 btn_press  output  NUM_BTN  one-cycle pulse per accepted press (and per auto-repeat when enabled).
REQ-012 rst_out_n  output  1  synchronised, stretched active-low reset for the downstream design.

Function
REQ-013 Each btn_raw bit and btn_rst SHALL pass through a two-flop synchroniser before any other use.
REQ-014 Each channel SHALL hold a counter of width $clog2(DEBOUNCE_CYCLES+1), cleared whenever the synchronised input equals btn_level.
REQ-015 While the synchronised input differs from btn_level the counter SHALL increment; when it reaches DEBOUNCE_CYCLES-1, btn_level SHALL toggle on the next edge and the counter SHALL clear.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change btn_level; total latency from raw edge to btn_level = 2 + DEBOUNCE_CYCLES cycles.
REQ-017 btn_press[i] SHALL be high for exactly the one cycle in which btn_level[i] transitions 0->1 becomes visible; no pulse on 1->0.
REQ-018 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce simultaneous pulses.
REQ-019 rst_out_n SHALL go low asynchronously on rst and synchronously (after the two-flop synchroniser) while synced btn_rst is 1.
REQ-020 After both rst and synced btn_rst are 0, rst_out_n SHALL stay low exactly RST_HOLD_CYCLES further cycles, then rise; reassertion of either source mid-count SHALL restart the count.
REQ-021 btn_rst SHALL NOT be debounced; any synchronised high cycle restarts the hold count.

Reset
REQ-022 On rst: synchronisers, debounce counters, repeat counters cleared; btn_level = 0, btn_press = 0, rst_out_n = 0.
REQ-023 rst SHALL take effect asynchronously; deassertion is sampled on clk and the RST_HOLD_CYCLES count starts on the first edge with rst low.
REQ-024 A button held through reset SHALL be re-accepted via the normal debounce path after reset release.

Configuration
REQ-025 Macro FPGA_BTN_AUTOREPEAT_EN SHALL select the auto-repeat feature.
REQ-026 With FPGA_BTN_AUTOREPEAT_EN defined: per-channel repeat counter; while btn_level[i]=1, btn_press[i] pulses REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles; release clears the counter immediately, no pulse in the release cycle.
REQ-027 Without FPGA_BTN_AUTOREPEAT_EN: no repeat counters synthesised; btn_press pulses only on 0->1 transitions; REPEAT_* parameters ignored.

Verification (NUM_BTN=4, DEBOUNCE_CYCLES=8, RST_HOLD_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-028 rst pulse, btn_raw=0 -> btn_level=0, btn_press=0, rst_out_n=0 during rst; rst_out_n rises on 4th edge after rst low.
REQ-029 btn_raw[1] high 5 cycles then low -> btn_level stays 4'b0000, no btn_press pulse.
REQ-030 btn_raw[2] held high -> btn_level[2]=1 at cycle 10 after raw edge, btn_press=4'b0100 for exactly one cycle; release -> btn_level[2]=0 ten cycles later, no pulse.
REQ-031 btn_raw[0] and btn_raw[3] rise same cycle -> btn_press=4'b1001 in one cycle.
REQ-032 btn_rst high 3 cycles mid-operation, again high 2 cycles into hold -> rst_out_n low throughout, rises 4 cycles after final synced release; btn_level unaffected.
REQ-033 FPGA_BTN_AUTOREPEAT_EN defined, btn_raw[0] held 40 cycles past acceptance -> pulses at +0, +20, +25, +30, +35; undefined -> single pulse at +0.
